// File: rtl/ber_test_controller_if.sv
// ber_test_controller_if
//   Datapath bus between the BER test sequencer and the channel under test.
//   tx_data  : test word presented to the datapath input
//   tx_valid : tx_data carries a test word this cycle
//   rx_data  : word returned by the datapath output
//   master modport : the sequencer (drives tx_*, observes rx_data)
//   slave  modport : the datapath (observes tx_*, drives rx_data)
interface ber_test_controller_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic [WIDTH-1:0] rx_data;

  modport master (output tx_data, output tx_valid, input rx_data);
  modport slave  (input tx_data, input tx_valid, output rx_data);
endinterface

// File: rtl/ber_test_controller.sv
// ber_test_controller
//   Run-to-completion bit-error-rate sequencer. On start it streams num_words
//   PRBS words into the datapath, regenerates the expected words through a
//   latency-matched delay line, compares returned words bit by bit and
//   accumulates bit/word error counts.
// Ports:
//   CLK, reset     : clock (rising edge), synchronous active-low reset
//   start, abort   : run request (IDLE only) / cancel a run in SEND or DRAIN
//   num_words      : words per run, latched with start
//   err_thresh     : error_flag is raised once bit_errors exceeds this
//   dp             : datapath bus (tx_data/tx_valid out, rx_data in)
//   busy, done     : run in progress / one-cycle completion pulse
//   bit_errors, word_errors, words_checked : result counters
//   error_flag     : sticky bit_errors > err_thresh
module ber_test_controller #(
  parameter int unsigned       WIDTH   = 12,
  parameter int unsigned       LAT     = 3,
  parameter int unsigned       CNT_W   = 50,
  parameter int unsigned       WORDS_W = 16,
  parameter logic [WIDTH-1:0]  SEED    = 12'hACE
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WORDS_W-1:0]   num_words,
  input  logic [CNT_W-1:0]     err_thresh,
  ber_test_controller_if.master dp,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bit_errors,
  output logic [WORDS_W-1:0]   word_errors,
  output logic [WORDS_W-1:0]   words_checked,
  output logic                 error_flag
);

  localparam int unsigned DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [WORDS_W-1:0] rem_q, rem_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               tx_valid_q, tx_valid_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   bit_err_q, bit_err_d;
  logic [WORDS_W-1:0] word_err_q, word_err_d;
  logic [WORDS_W-1:0] checked_q, checked_d;
  logic               flag_q, flag_d;
  logic [LAT-1:0]     dl_v_q, dl_v_d;
  logic [WIDTH-1:0]   dl_w_q [LAT];
  logic [WIDTH-1:0]   dl_w_d [LAT];

  logic [WIDTH-1:0]   diff;
  logic [CNT_W-1:0]   pc;
  logic [CNT_W:0]     bit_sum;
  logic               aborting;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    bit_err_d  = bit_err_q;
    word_err_d = word_err_q;
    checked_d  = checked_q;
    flag_d     = flag_q | (bit_err_q > err_thresh);
    diff       = '0;
    pc         = '0;
    bit_sum    = '0;
    aborting   = abort && (state_q == SEND || state_q == DRAIN);

    // Delay line shifts every cycle; stage 0 takes the registered tx word.
    dl_v_d[0] = tx_valid_q;
    dl_w_d[0] = tx_data_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      dl_v_d[i] = dl_v_q[i-1];
      dl_w_d[i] = dl_w_q[i-1];
    end

    // A compare landing in the abort cycle is dropped along with the flush.
    if (dl_v_q[LAT-1] && !aborting) begin
      diff = dp.rx_data ^ dl_w_q[LAT-1];
      for (int unsigned i = 0; i < WIDTH; i++) begin
        pc = pc + CNT_W'(diff[i]);
      end
      bit_sum    = {1'b0, bit_err_q} + {1'b0, pc};
      bit_err_d  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      word_err_d = word_err_q + WORDS_W'(diff != '0);
      checked_d  = checked_q + WORDS_W'(1);
    end

    // Outputs are registered from the current state, so each state's
    // effect appears on the ports one cycle after the state is entered.
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bit_err_d  = '0;
          word_err_d = '0;
          checked_d  = '0;
          flag_d     = 1'b0;
          rem_d      = num_words;
          lfsr_d     = SEED;
          state_d    = (num_words == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = lfsr_q;
          lfsr_d     = {lfsr_q[WIDTH-2:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
          rem_d      = rem_q - WORDS_W'(1);
          if (rem_q == WORDS_W'(1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // The last word needs LAT more cycles to reach the compare stage;
        // counting them is equivalent to watching the delay line empty.
        if (abort) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (drain_q == DW'(LAT - 1)) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q + DW'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (aborting) begin
      dl_v_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      rem_q      <= '0;
      drain_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bit_err_q  <= '0;
      word_err_q <= '0;
      checked_q  <= '0;
      flag_q     <= 1'b0;
      dl_v_q     <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        dl_w_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bit_err_q  <= bit_err_d;
      word_err_q <= word_err_d;
      checked_q  <= checked_d;
      flag_q     <= flag_d;
      dl_v_q     <= dl_v_d;
      dl_w_q     <= dl_w_d;
    end
  end

  assign dp.tx_data    = tx_data_q;
  assign dp.tx_valid   = tx_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bit_errors    = bit_err_q;
  assign word_errors   = word_err_q;
  assign words_checked = checked_q;
  assign error_flag    = flag_q;

endmodule

// File: tb/tb_ber_test_controller.sv
// Self-checking bench for ber_test_controller: a 3-cycle loopback channel
// with selectable corruption, a scoreboard of expected PRBS words, and
// directed runs covering reset, clean/errored runs, abort and edge cases.
module tb_ber_test_controller;
  localparam int unsigned WIDTH   = 12;
  localparam int unsigned LAT     = 3;
  localparam int unsigned CNT_W   = 50;
  localparam int unsigned WORDS_W = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               reset;
  logic               start;
  logic               abort;
  logic [WORDS_W-1:0] num_words;
  logic [CNT_W-1:0]   err_thresh;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   bit_errors;
  logic [WORDS_W-1:0] word_errors;
  logic [WORDS_W-1:0] words_checked;
  logic               error_flag;

  ber_test_controller_if #(.WIDTH(WIDTH)) dp ();

  ber_test_controller #(
    .WIDTH(WIDTH), .LAT(LAT), .CNT_W(CNT_W), .WORDS_W(WORDS_W), .SEED(12'hACE)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .num_words(num_words), .err_thresh(err_thresh), .dp(dp),
    .busy(busy), .done(done), .bit_errors(bit_errors),
    .word_errors(word_errors), .words_checked(words_checked),
    .error_flag(error_flag)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [$];
  int mode = 0;

  // Loopback channel: rx in cycle k+3 is word k, corrupted per mode.
  logic [WIDTH-1:0] ch_w [3];
  int               ch_idx [3];
  int               tx_idx = 0;

  function automatic logic [WIDTH-1:0] corrupt(input int m, input int idx);
    case (m)
      1:       return (idx % 2 == 0) ? 12'h001 : 12'h000;
      2:       return (idx == 3) ? 12'hFFF : 12'h000;
      3:       return 12'h001;
      default: return 12'h000;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (start === 1'b1 && busy !== 1'b1) tx_idx <= 0;
    else if (dp.tx_valid === 1'b1) tx_idx <= tx_idx + 1;
    ch_w[0]   <= dp.tx_data;
    ch_idx[0] <= tx_idx + 1;
    ch_w[1]   <= ch_w[0];
    ch_idx[1] <= ch_idx[0];
    ch_w[2]   <= ch_w[1];
    ch_idx[2] <= ch_idx[1];
  end

  assign dp.rx_data = ch_w[2] ^ corrupt(mode, ch_idx[2]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every word the DUT drives must match the next expected one.
  logic [WIDTH-1:0] mon_e;
  always @(negedge CLK) begin
    if (dp.tx_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL tx_unexpected: observed tx_data %0h expected no word", dp.tx_data);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("tx_data", 64'(dp.tx_data), 64'(mon_e));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_words(input int n);
    logic [11:0] l;
    l = 12'hACE;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(l);
      l = {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
    end
  endtask

  // Leaves the bench in cycle 0 (just after the edge that samples start).
  task automatic begin_run(input int n);
    num_words = WORDS_W'(n);
    start     = 1'b1;
    push_words(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int cur);
    int c;
    c = cur;
    while (done !== 1'b1 && c < cur + 300) begin
      tick();
      c++;
    end
    chk("done_cycle", 64'(c), 64'(n + int'(LAT) + 1));
    chk("busy_at_done", 64'(busy), 64'(0));
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "_tx_valid"}, 64'(dp.tx_valid), 64'(0));
    chk({ph, "_tx_data"}, 64'(dp.tx_data), 64'(0));
    chk({ph, "_busy"}, 64'(busy), 64'(0));
    chk({ph, "_done"}, 64'(done), 64'(0));
    chk({ph, "_bit_errors"}, 64'(bit_errors), 64'(0));
    chk({ph, "_word_errors"}, 64'(word_errors), 64'(0));
    chk({ph, "_words_checked"}, 64'(words_checked), 64'(0));
    chk({ph, "_error_flag"}, 64'(error_flag), 64'(0));
  endtask

  task automatic chk_counts(input string ph, input int b, input int w, input int n);
    chk({ph, "_bit_errors"}, 64'(bit_errors), 64'(b));
    chk({ph, "_word_errors"}, 64'(word_errors), 64'(w));
    chk({ph, "_words_checked"}, 64'(words_checked), 64'(n));
  endtask

  initial begin
    int seen_done;

    // Reset with random inputs.
    reset      = 1'b0;
    start      = 1'($urandom);
    abort      = 1'($urandom);
    num_words  = WORDS_W'($urandom);
    err_thresh = {18'($urandom), 32'($urandom)};
    tick();
    start     = 1'($urandom);
    abort     = 1'($urandom);
    num_words = WORDS_W'($urandom);
    tick();
    chk_zero("reset");
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) tick();
    chk("idle_tx_valid", 64'(dp.tx_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));

    // Clean loopback, N=10.
    mode       = 0;
    err_thresh = '0;
    begin_run(10);
    tick();
    chk("c1_busy", 64'(busy), 64'(1));
    chk("c1_tx_valid", 64'(dp.tx_valid), 64'(1));
    chk("c1_tx_data", 64'(dp.tx_data), 64'(12'hACE));
    tick();
    chk("c2_tx_data", 64'(dp.tx_data), 64'(12'h59C));
    wait_done(10, 2);
    chk_counts("clean", 0, 0, 10);
    tick();
    chk("clean_done_pulse", 64'(done), 64'(0));
    chk("clean_flag", 64'(error_flag), 64'(0));
    chk("clean_sb_empty", 64'(exp_q.size()), 64'(0));

    // Single-bit errors on even words, threshold 4 then 5.
    mode       = 1;
    err_thresh = 50'd4;
    begin_run(10);
    wait_done(10, 0);
    chk_counts("single", 5, 5, 10);
    tick();
    chk("single_flag_t4", 64'(error_flag), 64'(1));
    err_thresh = 50'd5;
    begin_run(10);
    chk("restart_flag_clr", 64'(error_flag), 64'(0));
    wait_done(10, 0);
    chk_counts("single5", 5, 5, 10);
    tick();
    chk("single_flag_t5", 64'(error_flag), 64'(0));

    // Burst on word 3.
    mode       = 2;
    err_thresh = 50'd100;
    begin_run(10);
    wait_done(10, 0);
    chk_counts("burst", 12, 1, 10);

    // Abort in cycle 5 of N=20 (every word carries a bit-0 error).
    mode = 3;
    begin_run(20);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_tx_valid", 64'(dp.tx_valid), 64'(0));
    exp_q.delete();
    seen_done = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1) seen_done = 1;
    end
    chk("abort_no_done", 64'(seen_done), 64'(0));
    chk_counts("abort_held", 1, 1, 1);

    // Restart clears counters; a start pulse while busy is ignored.
    mode = 0;
    begin_run(20);
    tick();
    chk_counts("restart_c1", 0, 0, 0);
    repeat (2) tick();
    num_words = 16'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, 4);
    chk_counts("restart", 0, 0, 20);
    chk("restart_sb_empty", 64'(exp_q.size()), 64'(0));

    // num_words = 0.
    begin_run(0);
    tick();
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    chk_counts("zero", 0, 0, 0);
    tick();
    chk("zero_done_off", 64'(done), 64'(0));

    // Reset in mid-DRAIN.
    mode = 3;
    begin_run(4);
    repeat (5) tick();
    chk("drain_busy", 64'(busy), 64'(1));
    chk("drain_bit_errors", 64'(bit_errors), 64'(1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_zero("drain_reset");
    seen_done = 0;
    repeat (10) begin
      tick();
      if (done === 1'b1) seen_done = 1;
    end
    chk("drain_reset_no_done", 64'(seen_done), 64'(0));
    chk("drain_reset_bits", 64'(bit_errors), 64'(0));
    chk("final_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ber_test_controller.md
# ber_test_controller

Self-checking BER test sequencer that drives the 12-bit channel datapath (encoder, channel, decoder chain) and scores its output.
- On `start` it streams `num_words` PRBS words into the datapath and regenerates the expected words through a latency-matched delay line.
- It compares each returned word bit by bit and accumulates bit-error and word-error counts.
- It replaces hand-written stimulus lists with a repeatable, run-to-completion measurement that reports `done` and an error-threshold flag.

## Interface
Parameters:
- `WIDTH`, 12: datapath word width.
- `LAT`, 3: datapath latency in cycles from `tx_data` to `rx_data`, ≥1.
- `CNT_W`, 50: bit-error counter width.
- `WORDS_W`, 16: word-count width.
- `SEED`, 12'hACE: LFSR seed, nonzero.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  run request, sampled in IDLE only.
- `abort`  in  1  cancel the current run.
- `num_words`  in  WORDS_W  words per run, sampled with `start`.
- `err_thresh`  in  CNT_W  bit-error threshold for `error_flag`.
- `tx_data`  out  WIDTH  word to datapath input.
- `tx_valid`  out  1  `tx_data` is a test word.
- `rx_data`  in  WIDTH  datapath output.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at run completion.
- `bit_errors`  out  CNT_W  accumulated erroneous bits.
- `word_errors`  out  WORDS_W  words with ≥1 bit error.
- `words_checked`  out  WORDS_W  words compared.
- `error_flag`  out  1  `bit_errors` > `err_thresh`; sticky.

## Operation
- Reset (`reset`=0 at a rising edge): FSM goes to IDLE; LFSR loads `SEED`; delay line is cleared. Every output goes to 0.
- FSM states: IDLE, SEND, DRAIN, DONE.
- IDLE, `start`=1:
  - Clears all counters and `error_flag`, latches `num_words`, loads LFSR with `SEED`.
  - If `num_words`=0, goes to DONE; otherwise goes to SEND.
- SEND:
  - Each cycle drives `tx_data`=LFSR and `tx_valid`=1, then advances the LFSR.
  - After the `num_words`-th word, goes to DRAIN.
- LFSR: Fibonacci, fb = q[11]^q[5]^q[3]^q[0]; next = {q[10:0], fb}. This gives `SEED`, 12'h59C, … for the default seed.
- Delay line: LAT-stage shift register of {valid, word}. It shifts every cycle in all states. Stage input is {`tx_valid`, `tx_data`}.
- Compare: when the delay-line output valid=1:
  - diff = `rx_data` ^ expected.
  - `bit_errors` += popcount(diff), saturating at all-ones.
  - `word_errors` += (diff≠0).
  - `words_checked` += 1.
- DRAIN: waits until the delay line holds no valid entries, then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE. Counters and `error_flag` hold until the next accepted `start`.
- `error_flag`: set on the cycle after `bit_errors` exceeds `err_thresh`; cleared only by `start` acceptance or reset.
- `abort`=1 in SEND or DRAIN:
  - Next state is IDLE; no `done`; delay line is flushed.
  - Counters hold their partial values.
  - `abort` is ignored in IDLE and DONE.
- Simultaneous `start` and `abort` in IDLE: `start` wins.
- `start` outside IDLE is ignored.

## Timing
- All outputs are registered.
- `start` is sampled at edge 0.
  - First `tx_valid`/`tx_data` appear after edge 1.
  - Word k (k=1..N) is driven in cycle k and compared against `rx_data` in cycle k+LAT.
  - Counter updates are visible one cycle after the compare.
- `busy`=1 from cycle 1 through cycle N+LAT.
- `done`=1 in cycle N+LAT+1, with `busy`=0 and final counts valid in that same cycle.
- `num_words`=0: `done` in cycle 1; counts 0; `busy` never asserts.
- Abort sampled in cycle a: `tx_valid`=0 and `busy`=0 in cycle a+1. No further counter updates after cycle a+1.
- Reset mid-run: the next cycle is identical to post-reset. No `done`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs → every output 0; `tx_valid` stays 0 with no `start`.
- Clean loopback: `rx_data` = `tx_data` delayed 3 cycles, `num_words`=10 → `tx_data` sequence begins 12'hACE, 12'h59C. `done` in cycle 14; bit_errors=0, word_errors=0, words_checked=10, `error_flag`=0.
- Single-bit errors: loopback with bit 0 inverted on even-numbered words, N=10, `err_thresh`=4 → bit_errors=5, word_errors=5, `error_flag`=1. Rerun with `err_thresh`=5 → `error_flag`=0.
- Burst error: invert all 12 bits of word 3 only, N=10 → bit_errors=12, word_errors=1, words_checked=10.
- Abort and restart:
  - `abort` in cycle 5 of N=20 → `busy` low in cycle 6, no `done`, words_checked=1 (held).
  - `start` pulsed while `busy` is ignored.
  - A new `start` clears all counters to 0 and the run completes normally.
- Edge cases:
  - `num_words`=0 → `done` in cycle 1, all counts 0.
  - `reset`=0 in mid-DRAIN → all outputs 0 next cycle, no `done`.
